// File: rtl/axi_lite_regfile_slave.sv
// ============================================================================
//  Module   : axi_lite_regfile_slave
//  Brief    : AXI4-Lite slave over a parametrised register file with byte
//             strobes, read-only mask, SLVERR decode and flattened export.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module axi_lite_regfile_slave #(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  ADDR_WIDTH = 7,
   parameter int                  NUM_REGS   = 32,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic [2:0]                     awprot,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic [2:0]                     arprot,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

   localparam int c_STRB_W = DATA_WIDTH / 8;
   localparam int c_LSB    = $clog2(c_STRB_W);
   localparam int c_IDX_W  = ADDR_WIDTH - c_LSB;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   logic                r_aw_held;
   logic [c_IDX_W-1:0]  r_aw_idx;
   logic                r_w_held;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [c_STRB_W-1:0] r_wstrb;
   logic                r_bvalid;
   logic [1:0]          r_bresp;
   logic                r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]          r_rresp;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic                  w_commit;
   logic [c_IDX_W-1:0]    w_wr_idx;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic [c_STRB_W-1:0]   w_wr_strb;
   logic                  w_wr_ok;
   logic [c_IDX_W-1:0]    w_rd_idx;
   logic                  w_rd_hit;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_unused;

   assign awready = !areset && !r_aw_held && !r_bvalid;
   assign wready  = !areset && !r_w_held && !r_bvalid;
   assign arready = !areset && !r_rvalid;
   assign bvalid  = r_bvalid;
   assign bresp   = r_bresp;
   assign rvalid  = r_rvalid;
   assign rdata   = r_rdata;
   assign rresp   = r_rresp;

   assign w_aw_hs  = awvalid && awready;
   assign w_w_hs   = wvalid && wready;
   assign w_ar_hs  = arvalid && arready;
   // A channel counts as available if already held or handshaking this edge.
   assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

   assign w_wr_idx  = r_aw_held ? r_aw_idx : awaddr[ADDR_WIDTH-1:c_LSB];
   assign w_wr_data = r_w_held ? r_wdata : wdata;
   assign w_wr_strb = r_w_held ? r_wstrb : wstrb;
   assign w_rd_idx  = araddr[ADDR_WIDTH-1:c_LSB];

   // Indices that match no implemented register fall through as errors.
   always_comb begin
      w_wr_ok   = 1'b0;
      w_rd_hit  = 1'b0;
      w_rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_wr_idx == c_IDX_W'(i)) w_wr_ok = !RO_MASK[i];
         if (w_rd_idx == c_IDX_W'(i)) begin
            w_rd_hit  = 1'b1;
            w_rd_data = r_regs[i];
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_regs <= '{default: '0};
      end else if (w_commit && w_wr_ok) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_idx == c_IDX_W'(i)) begin
               for (int b = 0; b < c_STRB_W; b++) begin
                  if (w_wr_strb[b]) r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_aw_held <= 1'b0;
         r_aw_idx  <= '0;
         r_w_held  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_ok ? 2'b00 : 2'b10;
         end else begin
            if (w_aw_hs) begin
               r_aw_held <= 1'b1;
               r_aw_idx  <= awaddr[ADDR_WIDTH-1:c_LSB];
            end
            if (w_w_hs) begin
               r_w_held <= 1'b1;
               r_wdata  <= wdata;
               r_wstrb  <= wstrb;
            end
            if (r_bvalid && bready) r_bvalid <= 1'b0;
         end
      end
   end

   // Read data is sampled before any same-edge write lands.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= 2'b00;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
         r_rresp  <= w_rd_hit ? 2'b00 : 2'b10;
      end else if (r_rvalid && rready) begin
         r_rvalid <= 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
         assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
      end
   endgenerate

   assign w_unused = ^{awprot, arprot, awaddr[c_LSB-1:0], araddr[c_LSB-1:0]};

endmodule

`default_nettype wire
